hc85_cascade_seq: RTL and testbench
===================================

HC85_CASCADE_SEQ -- requirements
Module: hc85_cascade_seq

Interface
REQ-001 The block SHALL have parameter NIB, default 4, meaning the number of 4-bit nibbles per operand (operand width 4*NIB, NIB >= 1).
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 START  input  1  request a compare; sampled only in IDLE.
REQ-005 A  input  4*NIB  operand A, latched on accepted START.
REQ-006 B  input  4*NIB  operand B, latched on accepted START.
REQ-007 BUSY  output  1  high while a compare is in progress.
REQ-008 DONE  output  1  one-cycle pulse; result valid.
REQ-009 GT, EQ, LT  output  1 each  registered result A>B, A=B, A<B; held until next DONE.
REQ-010 ERR  output  1  sticky cascade-integrity error (see Configuration).
REQ-011 CA, CB  output  4 each  nibble driven to the external HC_85 slice A3..A0 / B3..B0.
REQ-012 CI1, CI2, CI3  output  1 each  cascade inputs to the slice (I1 = ">", I2 = "=", I3 = "<").
REQ-013 CQ1, CQ2, CQ3  input  1 each  slice outputs (Q1 = ">", Q2 = "=", Q3 = "<"), combinational from CA/CB/CI*.

Function
REQ-014 The FSM SHALL have the states IDLE, DRIVE, SAMPLE and FIN, plus a nibble counter of width clog2(NIB), minimum 1.
REQ-015 IDLE with START=1 SHALL latch A and B, clear the counter, load the cascade register to (0,1,0), and go to DRIVE; START=0 SHALL keep the FSM in IDLE.
REQ-016 In DRIVE and SAMPLE, CA/CB SHALL equal nibble[counter] of the latched A/B (nibble 0 = bits 3:0, LSB-first), and CI1/CI2/CI3 SHALL equal the cascade register.
REQ-017 DRIVE SHALL last exactly one cycle as settle time, then go to SAMPLE.
REQ-018 At the SAMPLE edge, the block SHALL load the cascade register from {CQ1,CQ2,CQ3}; if counter < NIB-1, it SHALL increment the counter and go to DRIVE; otherwise it SHALL load {GT,EQ,LT} from {CQ1,CQ2,CQ3} and go to FIN.
REQ-019 FIN SHALL assert DONE for exactly one cycle and then go to IDLE; START SHALL be ignored in FIN.
REQ-020 BUSY SHALL be 1 in DRIVE and SAMPLE and 0 in IDLE and FIN; START while BUSY=1 SHALL be ignored, and the latched operands SHALL be unchanged.
REQ-021 Latency: with START accepted at edge t0, DONE and the new result SHALL be visible in the cycle after edge t0+2*NIB (after edge t0+8 for NIB=4); back-to-back throughput SHALL be one compare per 2*NIB+2 cycles.
REQ-022 In IDLE and FIN, CA and CB SHALL be 0 and CI1/CI2/CI3 SHALL be (0,1,0).
REQ-023 GT/EQ/LT SHALL change only on the edge entering FIN (or on reset).

Reset
REQ-024 RST=1 SHALL immediately force: state IDLE, counter 0, cascade register (0,1,0), BUSY=0, DONE=0, GT=0, EQ=1, LT=0, ERR=0, CA=CB=0, CI=(0,1,0).
REQ-025 RST asserted mid-compare SHALL abandon the operation with no DONE pulse; after release, the block SHALL accept a new START in the first cycle.

Configuration
REQ-026 With macro HC85_CASCADE_CHECK_EN defined, at every SAMPLE edge where {CQ1,CQ2,CQ3} is not exactly one-hot, the block SHALL set ERR (cleared only by reset), go to FIN, and load GT=EQ=LT=0.
REQ-027 Without HC85_CASCADE_CHECK_EN, the ERR port SHALL remain present and tied to 0, and CQ SHALL be captured unchecked.

Verification
REQ-028 A=16'h1234, B=16'h1234, START 1 cycle -> BUSY 8 cycles, DONE after edge t0+8, GT/EQ/LT=0/1/0.
REQ-029 A=16'h8000, B=16'h7FFF -> GT/EQ/LT=1/0/0; CI during nibble 3 = (0,0,1) (propagated "<" from low nibbles).
REQ-030 A=16'h0001, B=16'h0002 -> LT propagates through nibbles 1..3 via cascade; final GT/EQ/LT=0/0/1.
REQ-031 START pulsed again at the 3rd BUSY cycle with different A/B -> ignored; the result matches the first operands, with exactly one DONE.
REQ-032 RST pulsed during nibble 2 -> all outputs at reset values in the same cycle, no DONE; a new compare afterwards completes correctly.
REQ-033 HC85_CASCADE_CHECK_EN defined, bench forces CQ=000 during nibble 1 SAMPLE -> ERR=1, DONE next cycle, GT/EQ/LT=0/0/0, ERR held until RST.

Source files
------------

// File: rtl/hc85_cascade_seq.sv
// rtl/hc85_cascade_seq.sv - multi-nibble magnitude compare sequenced through one external HC_85 slice
// Optional macro HC85_CASCADE_CHECK_EN: flag non-one-hot slice outputs on ERR and abort the compare.
module hc85_cascade_seq #(
    parameter int NIB = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [4*NIB-1:0] i_a,
    input  logic [4*NIB-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_gt,
    output logic             o_eq,
    output logic             o_lt,
    output logic             o_err,
    output logic [3:0]       o_ca,
    output logic [3:0]       o_cb,
    output logic             o_ci1,
    output logic             o_ci2,
    output logic             o_ci3,
    input  logic             i_cq1,
    input  logic             i_cq2,
    input  logic             i_cq3
);

    localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [4*NIB-1:0] r_a;
    logic [4*NIB-1:0] r_b;
    logic [2:0]       r_casc;
    logic [2:0]       r_res;
    logic [2:0]       w_cq;
    logic             w_last;
    logic             w_bad;
    logic [4*NIB-1:0] w_sh_a;
    logic [4*NIB-1:0] w_sh_b;

    assign w_cq   = {i_cq1, i_cq2, i_cq3};
    assign w_last = (r_cnt == CW'(NIB - 1));

`ifdef HC85_CASCADE_CHECK_EN
    logic r_err;

    assign w_bad = (w_cq != 3'b100) && (w_cq != 3'b010) && (w_cq != 3'b001);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (r_state == S_SAMPLE && w_bad) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign w_bad = 1'b0;
    assign o_err = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_DRIVE;
            S_DRIVE:  w_next = S_SAMPLE;
            S_SAMPLE: w_next = (w_bad || w_last) ? S_FIN : S_DRIVE;
            S_FIN:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_casc  <= 3'b010;
            r_res   <= 3'b010;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a    <= i_a;
                        r_b    <= i_b;
                        r_cnt  <= '0;
                        r_casc <= 3'b010;
                    end
                end
                S_SAMPLE: begin
                    // The slice result of this nibble becomes the cascade input of the next one.
                    r_casc <= w_cq;
                    if (w_bad) begin
                        r_res <= 3'b000;
                    end else if (w_last) begin
                        r_res <= w_cq;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state == S_DRIVE) || (r_state == S_SAMPLE);
    assign o_done = (r_state == S_FIN);

    assign w_sh_a = r_a >> {r_cnt, 2'b00};
    assign w_sh_b = r_b >> {r_cnt, 2'b00};

    assign o_ca  = o_busy ? w_sh_a[3:0] : 4'd0;
    assign o_cb  = o_busy ? w_sh_b[3:0] : 4'd0;
    assign o_ci1 = o_busy ? r_casc[2] : 1'b0;
    assign o_ci2 = o_busy ? r_casc[1] : 1'b1;
    assign o_ci3 = o_busy ? r_casc[0] : 1'b0;

    assign o_gt = r_res[2];
    assign o_eq = r_res[1];
    assign o_lt = r_res[0];

endmodule

// File: tb/tb_hc85_cascade_seq.sv
// tb/tb_hc85_cascade_seq.sv - scoreboard bench for hc85_cascade_seq with a behavioural HC_85 slice
module tb_hc85_cascade_seq;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         o_busy, o_done, o_gt, o_eq, o_lt, o_err;
    logic [3:0]   o_ca, o_cb;
    logic         o_ci1, o_ci2, o_ci3;
    logic         cq1, cq2, cq3;

    hc85_cascade_seq #(.NIB(NIB)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_b(b),
        .o_busy(o_busy), .o_done(o_done), .o_gt(o_gt), .o_eq(o_eq), .o_lt(o_lt),
        .o_err(o_err), .o_ca(o_ca), .o_cb(o_cb),
        .o_ci1(o_ci1), .o_ci2(o_ci2), .o_ci3(o_ci3),
        .i_cq1(cq1), .i_cq2(cq2), .i_cq3(cq3)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slice: ">"/"<" decided by this nibble, otherwise the cascade passes through.
    int err_t = -1;
    always_comb begin
        if (cyc == err_t)      {cq1, cq2, cq3} = 3'b000;
        else if (o_ca > o_cb)  {cq1, cq2, cq3} = 3'b100;
        else if (o_ca < o_cb)  {cq1, cq2, cq3} = 3'b001;
        else                   {cq1, cq2, cq3} = {o_ci1, o_ci2, o_ci3};
    end

    typedef struct {
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [2:0]   res;
        int           t_done;
        int           blen;
        logic         err;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] rel(input logic [W-1:0] x, input logic [W-1:0] y);
        if (x > y) return 3'b100;
        if (x < y) return 3'b001;
        return 3'b010;
    endfunction

    // Relation of the k least significant nibbles; k=0 compares nothing and yields "=".
    function automatic logic [2:0] low_rel(input logic [W-1:0] x, input logic [W-1:0] y, input int k);
        logic [W-1:0] lx, ly;
        lx = x << (W - 4 * k);
        ly = y << (W - 4 * k);
        return rel(lx, ly);
    endfunction

    logic [2:0] last_res = 3'b010;
    logic       err_exp  = 1'b0;
    int         bcnt     = 0;

    always @(negedge clk) begin
        exp_t e;
        int   k;
        if (rst) begin
            q.delete();
            last_res = 3'b010;
            err_exp  = 1'b0;
            bcnt     = 0;
        end else begin
            if (o_busy) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL busy_without_op: busy=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    k = bcnt / 2;
                    chk("ca_nibble", {28'd0, o_ca}, {28'd0, q[0].ea[4*k +: 4]});
                    chk("cb_nibble", {28'd0, o_cb}, {28'd0, q[0].eb[4*k +: 4]});
                    chk("ci_cascade", {29'd0, o_ci1, o_ci2, o_ci3},
                        {29'd0, low_rel(q[0].ea, q[0].eb, k)});
                end
                bcnt++;
            end else begin
                chk("idle_ca_cb", {24'd0, o_ca, o_cb}, 32'd0);
                chk("idle_ci", {29'd0, o_ci1, o_ci2, o_ci3}, 32'b010);
            end
            if (o_done) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done: done=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("done_time", cyc, e.t_done);
                    chk("busy_len", bcnt, e.blen);
                    last_res = e.res;
                    if (e.err) err_exp = 1'b1;
                end
                bcnt = 0;
            end
            chk("result", {29'd0, o_gt, o_eq, o_lt}, {29'd0, last_res});
            chk("err", {31'd0, o_err}, {31'd0, err_exp});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((o_busy || o_done) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy=%0b done=%0b, expected idle", o_busy, o_done);
        end
    endtask

    task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input int err_at);
        exp_t e;
        int   t0;
        wait_idle();
        a     = xa;
        b     = xb;
        start = 1'b1;
        t0    = cyc + 1;
        e.ea  = xa;
        e.eb  = xb;
        if (err_at >= 0) begin
            err_t    = t0 + 2 * err_at + 1;
            e.res    = 3'b000;
            e.t_done = t0 + 2 * err_at + 2;
            e.blen   = 2 * err_at + 2;
            e.err    = 1'b1;
        end else begin
            err_t    = -1;
            e.res    = rel(xa, xb);
            e.t_done = t0 + 2 * NIB;
            e.blen   = 2 * NIB;
            e.err    = 1'b0;
        end
        q.push_back(e);
        step();
        start = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_busy_done"}, {30'd0, o_busy, o_done}, 32'd0);
        chk({tag, "_res"}, {29'd0, o_gt, o_eq, o_lt}, 32'b010);
        chk({tag, "_err"}, {31'd0, o_err}, 32'd0);
        chk({tag, "_ca_cb"}, {24'd0, o_ca, o_cb}, 32'd0);
        chk({tag, "_ci"}, {29'd0, o_ci1, o_ci2, o_ci3}, 32'b010);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d, expected 0", q.size());
        end
        step();
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int           mode;
        step();
        step();
        #1;
        check_reset_outs("reset");
        step();
        rst = 1'b0;

        issue(16'h1234, 16'h1234, -1);
        issue(16'h8000, 16'h7FFF, -1);
        issue(16'h0001, 16'h0002, -1);

        for (int i = 0; i < 24; i++) begin
            ra   = W'($urandom);
            mode = int'($urandom_range(0, 3));
            if (mode == 0)      rb = ra;
            else if (mode == 1) rb = ra ^ (W'($urandom_range(1, 15)) << (4 * $urandom_range(0, NIB - 1)));
            else                rb = W'($urandom);
            issue(ra, rb, -1);
        end

        // START during the third busy cycle must be ignored.
        issue(16'h3C5A, 16'h3C59, -1);
        step();
        step();
        a     = 16'h0000;
        b     = 16'hFFFF;
        start = 1'b1;
        step();
        start = 1'b0;
        drain();

        // Reset during nibble 2 abandons the compare.
        issue(16'h5A5A, 16'hA5A5, -1);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        #1;
        check_reset_outs("midrst");
        step();
        rst = 1'b0;
        issue(16'hBEEF, 16'hBEE0, -1);
        drain();

`ifdef HC85_CASCADE_CHECK_EN
        issue(16'h4321, 16'h4321, 1);
        issue(16'h1111, 16'h2222, -1);
        drain();
        step();
        rst = 1'b1;
        #1;
        check_reset_outs("errrst");
        step();
        rst = 1'b0;
        issue(16'hFFFF, 16'h0000, -1);
`endif

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
